// File: rtl/piece_mover.sv
// Applies gameplay commands to the falling piece; each candidate move is validated by the board checker.
// Commit 2+ cycles after the action; actions arriving while busy are dropped, NotPlay overrides everything.
module piece_mover #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int SPAWN_X = 3,
  parameter int SPAWN_Y = 0
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic [3:0] changeblock,
  input  logic [2:0] next_piece,
  input  logic       chk_ok,
  input  logic       chk_valid,
  output logic       chk_req,
  output logic [3:0] chk_x,
  output logic [4:0] chk_y,
  output logic [1:0] chk_rot,
  output logic [2:0] chk_type,
  output logic [3:0] piece_x,
  output logic [4:0] piece_y,
  output logic [1:0] piece_rot,
  output logic [2:0] piece_type,
  output logic       busy,
  output logic       moved,
  output logic       lock_pulse,
  output logic       game_over
);

  localparam logic [3:0] CODE_NOTPLAY = 4'd0;
  localparam logic [3:0] CODE_DROP    = 4'd2;
  localparam logic [3:0] CODE_LEFT    = 4'd3;
  localparam logic [3:0] CODE_RIGHT   = 4'd4;
  localparam logic [3:0] CODE_DOWN    = 4'd5;
  localparam logic [3:0] CODE_ROTATE  = 4'd6;

  localparam logic [3:0] MAX_X   = 4'(COLS - 1);
  localparam logic [4:0] MAX_Y   = 5'(ROWS - 1);
  localparam logic [3:0] SPAWN_C = 4'(SPAWN_X);
  localparam logic [4:0] SPAWN_R = 5'(SPAWN_Y);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOCK,
    SPAWN_CHK,
    OVER
  } state_t;

  state_t     state_q, state_d;
  logic       cand_down_q, cand_down_d;
  logic       load_cand;
  logic [3:0] cand_x_d;
  logic [4:0] cand_y_d;
  logic [1:0] cand_rot_d;
  logic [2:0] cand_type_d;
  logic       commit;
  logic       moved_d;
  logic       set_over;
  logic       restart;

  always_comb begin
    state_d     = state_q;
    load_cand   = 1'b0;
    cand_x_d    = piece_x;
    cand_y_d    = piece_y;
    cand_rot_d  = piece_rot;
    cand_type_d = piece_type;
    cand_down_d = cand_down_q;
    commit      = 1'b0;
    moved_d     = 1'b0;
    set_over    = 1'b0;
    restart     = 1'b0;

    if (changeblock == CODE_NOTPLAY) begin
      restart = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          case (changeblock)
            CODE_LEFT: begin
              if (piece_x != 4'd0) begin
                load_cand   = 1'b1;
                cand_x_d    = piece_x - 4'd1;
                cand_down_d = 1'b0;
                state_d     = CHECK;
              end
            end
            CODE_RIGHT: begin
              if (piece_x != MAX_X) begin
                load_cand   = 1'b1;
                cand_x_d    = piece_x + 4'd1;
                cand_down_d = 1'b0;
                state_d     = CHECK;
              end
            end
            CODE_ROTATE: begin
              load_cand   = 1'b1;
              cand_rot_d  = piece_rot + 2'd1;
              cand_down_d = 1'b0;
              state_d     = CHECK;
            end
            CODE_DROP, CODE_DOWN: begin
              // Stepping off the floor counts as blocked, so lock without asking the checker.
              if (piece_y == MAX_Y) begin
                state_d = LOCK;
              end else begin
                load_cand   = 1'b1;
                cand_y_d    = piece_y + 5'd1;
                cand_down_d = 1'b1;
                state_d     = CHECK;
              end
            end
            default: ;
          endcase
        end
        CHECK: begin
          if (chk_valid) begin
            if (chk_ok) begin
              commit  = 1'b1;
              moved_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = cand_down_q ? LOCK : IDLE;
            end
          end
        end
        LOCK: begin
          load_cand   = 1'b1;
          cand_x_d    = SPAWN_C;
          cand_y_d    = SPAWN_R;
          cand_rot_d  = 2'd0;
          cand_type_d = next_piece;
          cand_down_d = 1'b0;
          state_d     = SPAWN_CHK;
        end
        SPAWN_CHK: begin
          if (chk_valid) begin
            if (chk_ok) begin
              commit  = 1'b1;
              state_d = IDLE;
            end else begin
              set_over = 1'b1;
              state_d  = OVER;
            end
          end
        end
        OVER:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      piece_x     <= SPAWN_C;
      piece_y     <= SPAWN_R;
      piece_rot   <= 2'd0;
      piece_type  <= 3'd0;
      chk_x       <= 4'd0;
      chk_y       <= 5'd0;
      chk_rot     <= 2'd0;
      chk_type    <= 3'd0;
      cand_down_q <= 1'b0;
      moved       <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_q <= state_d;
      moved   <= moved_d;
      if (load_cand) begin
        chk_x       <= cand_x_d;
        chk_y       <= cand_y_d;
        chk_rot     <= cand_rot_d;
        chk_type    <= cand_type_d;
        cand_down_q <= cand_down_d;
      end
      if (restart) begin
        piece_x    <= SPAWN_C;
        piece_y    <= SPAWN_R;
        piece_rot  <= 2'd0;
        piece_type <= next_piece;
        game_over  <= 1'b0;
      end else begin
        if (commit) begin
          piece_x    <= chk_x;
          piece_y    <= chk_y;
          piece_rot  <= chk_rot;
          piece_type <= chk_type;
        end
        if (set_over) game_over <= 1'b1;
      end
    end
  end

  // The candidate registers are held while the request is up, so chk_req can follow state directly.
  assign chk_req    = (state_q == CHECK) || (state_q == SPAWN_CHK);
  assign busy       = (state_q != IDLE);
  assign lock_pulse = (state_q == LOCK);

endmodule
